// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates the fetch and load/store ports onto one
// mem_bus request, with alignment checking, load extension and a bus timeout.
//
// state     | meaning
// S_IDLE    | waiting for a request; misaligned data accesses are answered here
// S_BUS     | bus_start_request high, waiting for bus_request_done or timeout
// S_RELEASE | result delivered, waiting for bus_request_done to drop
module mem_access_ctrl #(
    parameter int ADDR_W  = 18,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    input  logic              ls_req,
    input  logic              ls_is_write,
    input  logic [2:0]        ls_funct3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_valid,
    output logic [31:0]       ls_rdata,
    output logic              ls_error,
    output logic              bus_start_request,
    output logic              bus_is_write,
    output logic [2:0]        bus_num_bytes,
    output logic [ADDR_W-1:0] bus_address,
    output logic [31:0]       bus_write_value,
    input  logic [31:0]       bus_fetched_value,
    input  logic              bus_request_done
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUS     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_fetch_q, is_fetch_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               bus_is_write_q, bus_is_write_d;
    logic [2:0]         bus_num_bytes_q, bus_num_bytes_d;
    logic [ADDR_W-1:0]  bus_address_q, bus_address_d;
    logic [31:0]        bus_write_value_q, bus_write_value_d;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        if_instr_q, if_instr_d;
    logic               ls_valid_q, ls_valid_d;
    logic               ls_error_q, ls_error_d;
    logic [31:0]        ls_rdata_q, ls_rdata_d;

    logic [2:0]         ls_nbytes;
    logic               ls_misaligned;
    logic [31:0]        ls_wdata_masked;
    logic [31:0]        load_ext;

    // Width decode; the reserved funct3 codes fall through to a word access.
    always_comb begin
        ls_nbytes       = 3'd4;
        ls_wdata_masked = ls_wdata;
        case (ls_funct3)
            3'b000, 3'b100: begin
                ls_nbytes       = 3'd1;
                ls_wdata_masked = {24'h0, ls_wdata[7:0]};
            end
            3'b001, 3'b101: begin
                ls_nbytes       = 3'd2;
                ls_wdata_masked = {16'h0, ls_wdata[15:0]};
            end
            default: begin
                ls_nbytes       = 3'd4;
                ls_wdata_masked = ls_wdata;
            end
        endcase
        ls_misaligned = !ls_addr[ADDR_W-1] &&
                        (((ls_nbytes == 3'd2) && ls_addr[0]) ||
                         ((ls_nbytes == 3'd4) && (ls_addr[1:0] != 2'b00)));
    end

    always_comb begin
        load_ext = bus_fetched_value;
        case (funct3_q)
            3'b000:  load_ext = {{24{bus_fetched_value[7]}}, bus_fetched_value[7:0]};
            3'b001:  load_ext = {{16{bus_fetched_value[15]}}, bus_fetched_value[15:0]};
            3'b100:  load_ext = {24'h0, bus_fetched_value[7:0]};
            3'b101:  load_ext = {16'h0, bus_fetched_value[15:0]};
            default: load_ext = bus_fetched_value;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        is_fetch_d        = is_fetch_q;
        funct3_d          = funct3_q;
        bus_is_write_d    = bus_is_write_q;
        bus_num_bytes_d   = bus_num_bytes_q;
        bus_address_d     = bus_address_q;
        bus_write_value_d = bus_write_value_q;
        if_valid_d        = 1'b0;
        if_instr_d        = if_instr_q;
        ls_valid_d        = 1'b0;
        ls_error_d        = 1'b0;
        ls_rdata_d        = ls_rdata_q;

        case (state_q)
            S_IDLE: begin
                // A request still high during its own valid pulse is already served.
                if (ls_req && !ls_valid_q) begin
                    is_fetch_d = 1'b0;
                    funct3_d   = ls_funct3;
                    if (ls_misaligned) begin
                        ls_valid_d = 1'b1;
                        ls_error_d = 1'b1;
                        ls_rdata_d = 32'h0;
                    end else begin
                        state_d           = S_BUS;
                        cnt_d             = '0;
                        bus_is_write_d    = ls_is_write;
                        bus_num_bytes_d   = ls_nbytes;
                        bus_address_d     = ls_addr;
                        bus_write_value_d = ls_wdata_masked;
                    end
                end else if (if_req) begin
                    state_d           = S_BUS;
                    cnt_d             = '0;
                    is_fetch_d        = 1'b1;
                    bus_is_write_d    = 1'b0;
                    bus_num_bytes_d   = 3'd4;
                    bus_address_d     = if_addr;
                    bus_write_value_d = 32'h0;
                end
            end
            S_BUS: begin
                if (bus_request_done) begin
                    state_d = S_RELEASE;
                    if (is_fetch_q) begin
                        if_valid_d = 1'b1;
                        if_instr_d = bus_fetched_value;
                    end else begin
                        ls_valid_d = 1'b1;
                        ls_rdata_d = bus_is_write_q ? 32'h0 : load_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RELEASE;
                    if (is_fetch_q) begin
                        if_valid_d = 1'b1;
                        if_instr_d = 32'h0;
                    end else begin
                        ls_valid_d = 1'b1;
                        ls_error_d = 1'b1;
                        ls_rdata_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (!bus_request_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            is_fetch_q        <= 1'b0;
            funct3_q          <= 3'b000;
            bus_is_write_q    <= 1'b0;
            bus_num_bytes_q   <= 3'd0;
            bus_address_q     <= '0;
            bus_write_value_q <= 32'h0;
            if_valid_q        <= 1'b0;
            if_instr_q        <= 32'h0;
            ls_valid_q        <= 1'b0;
            ls_error_q        <= 1'b0;
            ls_rdata_q        <= 32'h0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            is_fetch_q        <= is_fetch_d;
            funct3_q          <= funct3_d;
            bus_is_write_q    <= bus_is_write_d;
            bus_num_bytes_q   <= bus_num_bytes_d;
            bus_address_q     <= bus_address_d;
            bus_write_value_q <= bus_write_value_d;
            if_valid_q        <= if_valid_d;
            if_instr_q        <= if_instr_d;
            ls_valid_q        <= ls_valid_d;
            ls_error_q        <= ls_error_d;
            ls_rdata_q        <= ls_rdata_d;
        end
    end

    assign bus_start_request = (state_q == S_BUS);
    assign bus_is_write      = bus_is_write_q;
    assign bus_num_bytes     = bus_num_bytes_q;
    assign bus_address       = bus_address_q;
    assign bus_write_value   = bus_write_value_q;
    assign if_valid          = if_valid_q;
    assign if_instr          = if_instr_q;
    assign ls_valid          = ls_valid_q;
    assign ls_error          = ls_error_q;
    assign ls_rdata          = ls_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus random transactions checked
// against an arithmetic model of widths, alignment and load extension.
module tb_mem_access_ctrl;

    localparam int AW = 18;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic          ls_req = 1'b0;
    logic          ls_is_write = 1'b0;
    logic [2:0]    ls_funct3 = 3'b000;
    logic [AW-1:0] ls_addr = '0;
    logic [31:0]   ls_wdata = 32'h0;
    logic          ls_valid;
    logic [31:0]   ls_rdata;
    logic          ls_error;
    logic          bus_start_request;
    logic          bus_is_write;
    logic [2:0]    bus_num_bytes;
    logic [AW-1:0] bus_address;
    logic [31:0]   bus_write_value;
    logic [31:0]   bus_fetched_value = 32'h0;
    logic          bus_request_done = 1'b0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_valid          (if_valid),
        .if_instr          (if_instr),
        .ls_req            (ls_req),
        .ls_is_write       (ls_is_write),
        .ls_funct3         (ls_funct3),
        .ls_addr           (ls_addr),
        .ls_wdata          (ls_wdata),
        .ls_valid          (ls_valid),
        .ls_rdata          (ls_rdata),
        .ls_error          (ls_error),
        .bus_start_request (bus_start_request),
        .bus_is_write      (bus_is_write),
        .bus_num_bytes     (bus_num_bytes),
        .bus_address       (bus_address),
        .bus_write_value   (bus_write_value),
        .bus_fetched_value (bus_fetched_value),
        .bus_request_done  (bus_request_done)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_instr = 32'h0;
    logic [31:0] exp_rdata = 32'h0;
    bit          rdata_known = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int width_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_result(input logic [2:0] f3, input logic [31:0] v);
        longint span;
        longint r;
        int     n;
        n = width_of(f3);
        if (n == 4) return v;
        span = longint'(1) << (8 * n);
        r = longint'(v) % span;
        if ((f3 == 3'd0 || f3 == 3'd1) && r >= span / 2) r = r - span;
        return r[31:0];
    endfunction

    function automatic logic [31:0] store_value(input logic [31:0] w, input int n);
        longint r;
        if (n == 4) return w;
        r = longint'(w) % (longint'(1) << (8 * n));
        return r[31:0];
    endfunction

    function automatic bit is_misaligned(input logic [AW-1:0] a, input int n);
        int ai;
        ai = int'(a);
        return (ai < (1 << (AW - 1))) && ((ai % n) != 0);
    endfunction

    // One complete transaction on one port, starting and ending at a negedge with DUT idle.
    task automatic do_xact(input bit fetch, input bit wr, input logic [2:0] f3,
                           input logic [AW-1:0] addr, input logic [31:0] wdata,
                           input int lat, input logic [31:0] val, input int rel,
                           input bit tmo);
        int          n;
        logic [31:0] res;
        n = fetch ? 4 : width_of(f3);
        if (fetch) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            ls_req      = 1'b1;
            ls_is_write = wr;
            ls_funct3   = f3;
            ls_addr     = addr;
            ls_wdata    = wdata;
        end
        tick();
        if (!fetch && is_misaligned(addr, n)) begin
            check("mis_start", 32'(bus_start_request), 32'd0);
            check("mis_valid", 32'(ls_valid), 32'd1);
            check("mis_error", 32'(ls_error), 32'd1);
            check("mis_rdata", ls_rdata, 32'h0);
            exp_rdata   = 32'h0;
            rdata_known = 1'b1;
            ls_req = 1'b0;
            tick();
            check("mis_pulse", 32'(ls_valid), 32'd0);
            check("mis_no_bus", 32'(bus_start_request), 32'd0);
            return;
        end
        check("start_rise", 32'(bus_start_request), 32'd1);
        check("bus_we", 32'(bus_is_write), fetch ? 32'd0 : 32'(wr));
        check("bus_nbytes", 32'(bus_num_bytes), 32'(n));
        check("bus_addr", 32'(bus_address), 32'(addr));
        if (!fetch && wr) check("bus_wval", bus_write_value, store_value(wdata, n));
        if (tmo) begin
            for (int i = 1; i < TO; i++) begin
                tick();
                check("tmo_start_hold", 32'(bus_start_request), 32'd1);
            end
            tick();
            check("tmo_start_drop", 32'(bus_start_request), 32'd0);
            if (fetch) begin
                check("tmo_if_valid", 32'(if_valid), 32'd1);
                check("tmo_if_instr", if_instr, 32'h0);
                exp_instr = 32'h0;
            end else begin
                check("tmo_ls_valid", 32'(ls_valid), 32'd1);
                check("tmo_ls_error", 32'(ls_error), 32'd1);
                rdata_known = 1'b0;
            end
            if_req = 1'b0;
            ls_req = 1'b0;
        end else begin
            for (int i = 1; i < lat; i++) begin
                tick();
                check("start_hold", 32'(bus_start_request), 32'd1);
            end
            bus_request_done  = 1'b1;
            bus_fetched_value = val;
            tick();
            check("done_start_drop", 32'(bus_start_request), 32'd0);
            if (fetch) begin
                check("if_valid", 32'(if_valid), 32'd1);
                check("if_other_valid", 32'(ls_valid), 32'd0);
                check("if_instr", if_instr, val);
                exp_instr = val;
            end else begin
                res = wr ? 32'h0 : load_result(f3, val);
                check("ls_valid", 32'(ls_valid), 32'd1);
                check("ls_other_valid", 32'(if_valid), 32'd0);
                check("ls_error", 32'(ls_error), 32'd0);
                check("ls_rdata", ls_rdata, res);
                exp_rdata   = res;
                rdata_known = 1'b1;
            end
            if_req = 1'b0;
            ls_req = 1'b0;
            for (int i = 1; i < rel; i++) begin
                tick();
                check("release_start_low", 32'(bus_start_request), 32'd0);
                check("release_no_valid", 32'(if_valid | ls_valid), 32'd0);
            end
            bus_request_done = 1'b0;
        end
        tick();
        check("idle_start_low", 32'(bus_start_request), 32'd0);
        check("hold_if_instr", if_instr, exp_instr);
        if (rdata_known) check("hold_ls_rdata", ls_rdata, exp_rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    initial begin
        bit            f;
        bit            wr;
        logic [2:0]    f3;
        logic [AW-1:0] a;

        rst_n = 1'b0;
        tick();
        tick();
        check("rst_start", 32'(bus_start_request), 32'd0);
        check("rst_valids", 32'({if_valid, ls_valid, ls_error}), 32'd0);
        check("rst_bus_fields", 32'({bus_is_write, bus_num_bytes}), 32'd0);
        check("rst_bus_addr", 32'(bus_address), 32'd0);
        check("rst_bus_wval", bus_write_value, 32'h0);
        check("rst_outs", if_instr | ls_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        do_xact(1'b1, 1'b0, 3'd2, 18'h00010, 32'h0, 8, 32'h00500513, 2, 1'b0);
        check("fetch_const", if_instr, 32'h00500513);
        do_xact(1'b0, 1'b0, 3'd0, 18'h20003, 32'h0, 3, 32'h00000080, 1, 1'b0);
        check("lb_const", ls_rdata, 32'hFFFFFF80);
        do_xact(1'b0, 1'b0, 3'd4, 18'h20003, 32'h0, 2, 32'h00000080, 1, 1'b0);
        check("lbu_const", ls_rdata, 32'h00000080);
        do_xact(1'b0, 1'b1, 3'd1, 18'h00101, 32'h12345678, 1, 32'h0, 1, 1'b0);
        do_xact(1'b0, 1'b1, 3'd1, 18'h20000, 32'h12345678, 4, 32'h0, 2, 1'b0);
        do_xact(1'b0, 1'b0, 3'd2, 18'h10002, 32'h0, 1, 32'h0, 1, 1'b0);
        do_xact(1'b0, 1'b0, 3'd7, 18'h00004, 32'h0, 2, 32'hCAFEF00D, 1, 1'b0);
        do_xact(1'b0, 1'b0, 3'd2, 18'h00100, 32'h0, 1, 32'h0, 1, 1'b1);
        do_xact(1'b1, 1'b0, 3'd2, 18'h00200, 32'h0, 1, 32'h0, 1, 1'b1);

        // Both ports request together: data goes first, fetch waits out RELEASE.
        ls_req = 1'b1; ls_is_write = 1'b0; ls_funct3 = 3'd2;
        ls_addr = 18'h00040; if_req = 1'b1; if_addr = 18'h00080;
        tick();
        check("prio_start", 32'(bus_start_request), 32'd1);
        check("prio_data_first", 32'(bus_address), 32'h00040);
        tick();
        bus_request_done = 1'b1; bus_fetched_value = 32'h11223344;
        tick();
        check("prio_ls_valid", 32'(ls_valid), 32'd1);
        check("prio_if_not_valid", 32'(if_valid), 32'd0);
        check("prio_ls_rdata", ls_rdata, 32'h11223344);
        exp_rdata = 32'h11223344; rdata_known = 1'b1;
        ls_req = 1'b0;
        tick();
        check("prio_release_low", 32'(bus_start_request), 32'd0);
        bus_request_done = 1'b0;
        tick();
        check("prio_idle_low", 32'(bus_start_request), 32'd0);
        tick();
        check("prio_fetch_start", 32'(bus_start_request), 32'd1);
        check("prio_fetch_addr", 32'(bus_address), 32'h00080);
        check("prio_fetch_nbytes", 32'(bus_num_bytes), 32'd4);
        bus_request_done = 1'b1; bus_fetched_value = 32'hA5A5_0001;
        tick();
        check("prio_if_valid", 32'(if_valid), 32'd1);
        check("prio_if_instr", if_instr, 32'hA5A5_0001);
        exp_instr = 32'hA5A5_0001;
        if_req = 1'b0; bus_request_done = 1'b0;
        tick();
        check("prio_end_low", 32'(bus_start_request), 32'd0);

        // Reset in the middle of a bus cycle.
        ls_req = 1'b1; ls_is_write = 1'b1; ls_funct3 = 3'd2;
        ls_addr = 18'h00100; ls_wdata = 32'hDEADBEEF;
        tick();
        check("rstmid_start", 32'(bus_start_request), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        check("rstmid_start_drop", 32'(bus_start_request), 32'd0);
        check("rstmid_addr", 32'(bus_address), 32'd0);
        check("rstmid_wval", bus_write_value, 32'h0);
        check("rstmid_outs", if_instr | ls_rdata, 32'h0);
        ls_req = 1'b0;
        exp_instr = 32'h0; exp_rdata = 32'h0; rdata_known = 1'b1;
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 40; k++) begin
            f  = ($urandom_range(3) == 0);
            wr = ($urandom_range(1) == 1);
            f3 = wr ? 3'($urandom_range(2)) : 3'($urandom_range(7));
            a  = AW'($urandom);
            if ($urandom_range(2) == 0) a[1:0] = 2'b00;
            do_xact(f, wr, f3, a, $urandom, $urandom_range(12, 1), $urandom,
                    $urandom_range(3, 1), $urandom_range(9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
